// File: rtl/raymarch_pkg.sv
// Shared types and helpers for the sphere-tracing core: a wide signed
// fixed-point container, the fixed-point multiply, the march FSM states
// and a real-to-fixed-point constant converter used at elaboration.
package raymarch_pkg;

  // Widest fixed-point word any instance may use; narrower formats are
  // sign-extended into it and truncated back after the multiply.
  localparam int FX_MAX_W = 64;

  typedef logic signed [FX_MAX_W-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    SQRT,
    EVAL,
    DONE
  } state_t;

  // Full-width signed product, arithmetic shift by the fraction width.
  // The caller truncates the result to its own word width (no saturation).
  function automatic fx_t fxmul(input fx_t a, input fx_t b, input int frac);
    logic signed [2*FX_MAX_W-1:0] prod;
    prod = (2 * FX_MAX_W)'(a) * (2 * FX_MAX_W)'(b);
    return fx_t'(prod >>> frac);
  endfunction

  // Converts a real constant to fixed point with the given fraction bits.
  function automatic longint fx_const(input real value, input int frac);
    return longint'(value * real'(longint'(1) << frac));
  endfunction

endpackage

// File: rtl/fx_sqrt.sv
// Iterative restoring integer square root: a 2*W-bit radicand yields a
// W-bit root, one root bit per clock. done rises W cycles after start and
// stays high until the next start.
module fx_sqrt #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic [W-1:0]   root,
  output logic           done
);

  localparam int CW = $clog2(W + 1);
  localparam int RW = W + 2;

  logic [2*W-1:0] rad_reg;
  logic [RW-1:0]  rem_reg;
  logic [W-1:0]   root_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [W+3:0]   rem_shift;
  logic [W+3:0]   trial;
  logic           fits;

  // Bring down the next radicand bit pair and test it against 4*root+1
  always_comb begin
    rem_shift = {rem_reg, rad_reg[2*W-1 -: 2]};
    trial     = {2'b00, root_reg, 2'b01};
    fits      = (rem_shift >= trial);
  end

  // One restoring step per cycle while busy; a new start restarts cleanly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_reg  <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      rad_reg  <= radicand;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= CW'(W);
      busy_reg <= 1'b1;
      done_reg <= 1'b0;
    end else if (busy_reg) begin
      rad_reg  <= rad_reg << 2;
      rem_reg  <= fits ? RW'(rem_shift - trial) : RW'(rem_shift);
      root_reg <= {root_reg[W-2:0], fits};
      cnt_reg  <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign root = root_reg;
  assign done = done_reg;

endmodule

// File: rtl/raymarch_core.sv
// Sphere-tracing core: accepts a tagged unit-direction ray, marches it from
// the camera origin against a single-sphere SDF and returns hit flag, step
// count and step-shaded gray, both sides over valid/ready handshakes.
module raymarch_core
  import raymarch_pkg::*;
#(
  parameter int     FX_W        = 32,
  parameter int     FX_FRAC     = 8,
  parameter int     TAG_W       = 11,
  parameter longint CAM_Z       = fx_const(-4.0, FX_FRAC),
  parameter longint SPH_X       = 0,
  parameter longint SPH_Y       = 0,
  parameter longint SPH_Z       = 0,
  parameter longint SPH_R       = fx_const(1.0, FX_FRAC),
  parameter longint HIT_EPS     = fx_const(0.0625, FX_FRAC),
  parameter longint T_MAX       = fx_const(16.0, FX_FRAC),
  parameter int     MAX_STEPS   = 64,
  parameter int     SHADE_SHIFT = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               ray_valid_in,
  output logic                               ray_ready_out,
  input  logic [TAG_W-1:0]                   pix_x_in,
  input  logic [TAG_W-1:0]                   pix_y_in,
  input  logic signed [FX_W-1:0]             dir_x_in,
  input  logic signed [FX_W-1:0]             dir_y_in,
  input  logic signed [FX_W-1:0]             dir_z_in,
  output logic                               result_valid_out,
  input  logic                               result_ready_in,
  output logic [TAG_W-1:0]                   pix_x_out,
  output logic [TAG_W-1:0]                   pix_y_out,
  output logic                               hit_out,
  output logic [$clog2(MAX_STEPS+1)-1:0]     steps_out,
  output logic [7:0]                         red_out,
  output logic [7:0]                         green_out,
  output logic [7:0]                         blue_out
);

  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam int PW = 2 * FX_W;
  localparam int MW = PW + 2;

  typedef logic signed [FX_W-1:0] fxw_t;

  localparam fxw_t SPH_R_FX   = fxw_t'(SPH_R);
  localparam fxw_t HIT_EPS_FX = fxw_t'(HIT_EPS);
  localparam fxw_t T_MAX_FX   = fxw_t'(T_MAX);

  state_t           state_reg, state_next;
  logic             accept, advance, hit_cond, stop_cond;
  logic             sqrt_start, sqrt_done;
  logic [FX_W-1:0]  sqrt_root;
  logic [TAG_W-1:0] tag_x_reg, tag_y_reg;
  fxw_t             t_reg, d_reg;
  logic [SW-1:0]    steps_reg;
  logic             hit_reg;
  logic [PW-1:0]    sq_arr [3];
  logic [MW-1:0]    magsq_sum;
  logic [PW-1:0]    magsq;
  logic [31:0]      shade_steps;
  logic [7:0]       gray;

  assign accept    = (state_reg == IDLE) && ray_valid_in;
  assign hit_cond  = (d_reg <= HIT_EPS_FX);
  assign stop_cond = (t_reg >= T_MAX_FX) || (steps_reg == SW'(MAX_STEPS));
  assign advance   = (state_reg == EVAL) && !hit_cond && !stop_cond;

  // Per-axis direction, position and squared offset from the sphere centre
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    localparam fxw_t CENTRE = fxw_t'((gi == 0) ? SPH_X : (gi == 1) ? SPH_Y : SPH_Z);
    localparam fxw_t ORIGIN = fxw_t'((gi == 2) ? CAM_Z : longint'(0));

    fxw_t                 dir_in, dir_reg, p_reg, delta;
    logic signed [PW-1:0] delta_w;

    assign dir_in     = (gi == 0) ? dir_x_in : (gi == 1) ? dir_y_in : dir_z_in;
    assign delta      = p_reg - CENTRE;
    assign delta_w    = PW'(delta);
    assign sq_arr[gi] = delta_w * delta_w;

    // Latch the direction on accept; step the position along it on advance
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        dir_reg <= '0;
        p_reg   <= '0;
      end else if (accept) begin
        dir_reg <= dir_in;
        p_reg   <= ORIGIN;
      end else if (advance) begin
        p_reg <= p_reg + FX_W'(fxmul(fx_t'(d_reg), fx_t'(dir_reg), FX_FRAC));
      end
    end
  end

  // Squared distance to the centre, clamped to the radicand width
  always_comb begin
    magsq_sum = MW'(sq_arr[0]) + MW'(sq_arr[1]) + MW'(sq_arr[2]);
    magsq     = (|magsq_sum[MW-1:PW]) ? '1 : magsq_sum[PW-1:0];
  end

  fx_sqrt #(
    .W(FX_W)
  ) u_sqrt (
    .clk      (clk_in),
    .rst      (rst_in),
    .start    (sqrt_start),
    .radicand (magsq),
    .root     (sqrt_root),
    .done     (sqrt_done)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: a root makes d, EVAL decides hit / give up / step
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (ray_valid_in) state_next = SQ;
      SQ:      state_next = SQRT;
      SQRT:    if (sqrt_done) state_next = EVAL;
      EVAL:    state_next = (hit_cond || stop_cond) ? DONE : SQ;
      DONE:    if (result_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs and sqrt kick-off decoded from the state
  always_comb begin
    ray_ready_out    = 1'b0;
    result_valid_out = 1'b0;
    sqrt_start       = 1'b0;
    unique case (state_reg)
      IDLE:    ray_ready_out    = 1'b1;
      SQ:      sqrt_start       = 1'b1;
      DONE:    result_valid_out = 1'b1;
      default: ;
    endcase
  end

  // March bookkeeping: tag, distance travelled, step count, SDF value, hit
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_x_reg <= '0;
      tag_y_reg <= '0;
      t_reg     <= '0;
      d_reg     <= '0;
      steps_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      if (accept) begin
        tag_x_reg <= pix_x_in;
        tag_y_reg <= pix_y_in;
        t_reg     <= '0;
        steps_reg <= '0;
        hit_reg   <= 1'b0;
      end
      if ((state_reg == SQRT) && sqrt_done) begin
        d_reg <= $signed(sqrt_root) - SPH_R_FX;
      end
      if ((state_reg == EVAL) && hit_cond) begin
        hit_reg <= 1'b1;
      end
      if (advance) begin
        t_reg     <= t_reg + d_reg;
        steps_reg <= steps_reg + SW'(1);
      end
    end
  end

  // Fewer steps means a brighter pixel; misses stay black
  always_comb begin
    shade_steps = 32'(steps_reg) << SHADE_SHIFT;
    gray        = (shade_steps >= 32'd255) ? 8'd0 : 8'(32'd255 - shade_steps);
  end

  assign pix_x_out = tag_x_reg;
  assign pix_y_out = tag_y_reg;
  assign hit_out   = hit_reg;
  assign steps_out = steps_reg;
  assign red_out   = hit_reg ? gray : 8'd0;
  assign green_out = hit_reg ? gray : 8'd0;
  assign blue_out  = hit_reg ? gray : 8'd0;

endmodule

// File: tb/tb_raymarch_core.sv
// Bench for raymarch_core: directed cases plus randomized rays checked
// against a plain-arithmetic sphere-tracing model.
module tb_raymarch_core;
  import raymarch_pkg::*;

  localparam int TAG_W = 11;
  localparam int SW    = 7;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             ray_valid_in = 1'b0;
  logic             result_ready_in = 1'b0;
  logic [TAG_W-1:0] pix_x_in = '0;
  logic [TAG_W-1:0] pix_y_in = '0;
  logic signed [31:0] dir_x_in = '0;
  logic signed [31:0] dir_y_in = '0;
  logic signed [31:0] dir_z_in = '0;
  logic             ray_ready_out, result_valid_out, hit_out;
  logic [TAG_W-1:0] pix_x_out, pix_y_out;
  logic [SW-1:0]    steps_out;
  logic [7:0]       red_out, green_out, blue_out;

  logic             lim_valid = 1'b0;
  logic             lim_take = 1'b0;
  logic             lim_ready, lim_result_valid, lim_hit;
  logic [TAG_W-1:0] lim_pix_x, lim_pix_y;
  logic [0:0]       lim_steps;
  logic [7:0]       lim_red, lim_green, lim_blue;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  raymarch_core dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .ray_valid_in(ray_valid_in), .ray_ready_out(ray_ready_out),
    .pix_x_in(pix_x_in), .pix_y_in(pix_y_in),
    .dir_x_in(dir_x_in), .dir_y_in(dir_y_in), .dir_z_in(dir_z_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
    .hit_out(hit_out), .steps_out(steps_out),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
  );

  raymarch_core #(
    .MAX_STEPS(1),
    .T_MAX(fx_const(1000.0, 8))
  ) dut_lim (
    .clk_in(clk_in), .rst_in(rst_in),
    .ray_valid_in(lim_valid), .ray_ready_out(lim_ready),
    .pix_x_in(pix_x_in), .pix_y_in(pix_y_in),
    .dir_x_in(dir_x_in), .dir_y_in(dir_y_in), .dir_z_in(dir_z_in),
    .result_valid_out(lim_result_valid), .result_ready_in(lim_take),
    .pix_x_out(lim_pix_x), .pix_y_out(lim_pix_y),
    .hit_out(lim_hit), .steps_out(lim_steps),
    .red_out(lim_red), .green_out(lim_green), .blue_out(lim_blue)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Largest r with r*r <= m, by binary search over the 32-bit root range
  function automatic longint isqrt(input logic [127:0] m);
    longint lo = 0;
    longint hi = 64'h1_0000_0000;
    while (hi - lo > 1) begin
      longint mid = (lo + hi) / 2;
      logic [127:0] sq = 128'(mid) * 128'(mid);
      if (sq <= m) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // Sphere tracing written out directly: unit sphere at the origin,
  // camera at z=-4.0, 8 fraction bits, 32-bit wrapping integers.
  task automatic model_march(input int dx, input int dy, input int dz,
                             input int max_steps, input int t_max,
                             output bit hit, output int steps);
    int p[3];
    int dir[3];
    int t;
    int d;
    bit fin;
    logic [127:0] m;
    p = '{0, 0, -1024};
    dir = '{dx, dy, dz};
    t = 0;
    steps = 0;
    hit = 0;
    fin = 0;
    while (!fin) begin
      m = 0;
      for (int a = 0; a < 3; a++) m += 128'(longint'(p[a]) * longint'(p[a]));
      if (m > 128'hFFFF_FFFF_FFFF_FFFF) m = 128'hFFFF_FFFF_FFFF_FFFF;
      d = int'(isqrt(m)) - 256;
      if (d <= 16) begin
        hit = 1;
        fin = 1;
      end else if (t >= t_max || steps == max_steps) begin
        hit = 0;
        fin = 1;
      end else begin
        for (int a = 0; a < 3; a++) p[a] += int'((longint'(d) * longint'(dir[a])) >>> 8);
        t += d;
        steps++;
      end
    end
  endtask

  // Offers a ray from a negedge; returns at the negedge after acceptance
  task automatic send_ray(input int x, input int y, input int dx, input int dy,
                          input int dz, input bit hold);
    int c;
    pix_x_in = TAG_W'(x);
    pix_y_in = TAG_W'(y);
    dir_x_in = dx;
    dir_y_in = dy;
    dir_z_in = dz;
    ray_valid_in = 1'b1;
    c = 0;
    while (!ray_ready_out && c < 200) begin
      @(negedge clk_in);
      c++;
    end
    if (!ray_ready_out) check("accept_timeout", 0, 1);
    @(negedge clk_in);
    if (!hold) ray_valid_in = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    for (int c = 0; c < 5000 && !result_valid_out; c++) @(negedge clk_in);
    ok = result_valid_out;
  endtask

  task automatic take_result();
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
  endtask

  task automatic check_result(input string name, input int x, input int y,
                              input bit exp_hit, input int exp_steps);
    int gray;
    gray = exp_hit ? 255 - ((exp_steps * 4 > 255) ? 255 : exp_steps * 4) : 0;
    $display("[TB] %s tag=(%0d,%0d) hit=%0d steps=%0d rgb=(%0d,%0d,%0d) ref hit=%0d steps=%0d",
             name, pix_x_out, pix_y_out, hit_out, steps_out, red_out, green_out, blue_out,
             exp_hit, exp_steps);
    check({name, " valid"}, result_valid_out, 1);
    check({name, " pix_x"}, pix_x_out, x);
    check({name, " pix_y"}, pix_y_out, y);
    check({name, " hit"}, hit_out, exp_hit);
    check({name, " steps"}, steps_out, exp_steps);
    check({name, " red"}, red_out, gray);
    check({name, " green"}, green_out, gray);
    check({name, " blue"}, blue_out, gray);
  endtask

  task automatic run_ray(input string name, input int x, input int y, input int dx,
                         input int dy, input int dz, input int stall);
    bit exp_hit;
    int exp_steps;
    bit ok;
    model_march(dx, dy, dz, 64, 4096, exp_hit, exp_steps);
    send_ray(x, y, dx, dy, dz, 1'b0);
    wait_result(ok);
    check({name, " done"}, ok, 1);
    if (ok) begin
      repeat (stall) @(negedge clk_in);
      check_result(name, x, y, exp_hit, exp_steps);
      take_result();
    end
  endtask

  initial begin
    bit ok;
    bit exp_hit;
    int exp_steps;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst ray_ready", ray_ready_out, 1);
    check("rst result_valid", result_valid_out, 0);
    check("rst outputs", {hit_out, steps_out, red_out, green_out, blue_out, pix_x_out, pix_y_out}, 0);
    check("rst lim ray_ready", lim_ready, 1);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Straight hit: d=3.0 then d=0, one advance
    send_ray(180, 200, 0, 0, 256, 1'b0);
    wait_result(ok);
    check("straight done", ok, 1);
    check_result("straight", 180, 200, 1, 1);
    take_result();
    check("straight ready_after", ray_ready_out, 1);

    // Miss by far plane
    model_march(256, 0, 0, 64, 4096, exp_hit, exp_steps);
    send_ray(3, 4, 256, 0, 0, 1'b0);
    wait_result(ok);
    check("far done", ok, 1);
    check_result("far", 3, 4, 0, exp_steps);
    check("far steps_lt_max", steps_out < 64, 1);
    take_result();

    // Step limit on the MAX_STEPS=1 instance
    dir_x_in = 256;
    dir_y_in = 0;
    dir_z_in = 0;
    pix_x_in = 11'd9;
    pix_y_in = 11'd10;
    lim_valid = 1'b1;
    @(negedge clk_in);
    lim_valid = 1'b0;
    for (int c = 0; c < 2000 && !lim_result_valid; c++) @(negedge clk_in);
    $display("[TB] steplimit hit=%0d steps=%0d rgb=%0d", lim_hit, lim_steps, lim_red);
    check("lim valid", lim_result_valid, 1);
    check("lim hit", lim_hit, 0);
    check("lim steps", lim_steps, 1);
    check("lim rgb", {lim_red, lim_green, lim_blue}, 0);
    lim_take = 1'b1;
    @(negedge clk_in);
    lim_take = 1'b0;

    // Back-pressure: result held for 20 cycles
    send_ray(180, 200, 0, 0, 256, 1'b0);
    wait_result(ok);
    check("bp done", ok, 1);
    for (int c = 0; c < 20; c++) begin
      check("bp hold",
            {result_valid_out, ray_ready_out, hit_out, steps_out, red_out, green_out, blue_out, pix_x_out, pix_y_out},
            {1'b1, 1'b0, 1'b1, 7'd1, 8'd251, 8'd251, 8'd251, 11'd180, 11'd200});
      @(negedge clk_in);
    end
    $display("[TB] backpressure held 20 cycles, taking result");
    take_result();
    check("bp ready_after_take", ray_ready_out, 1);
    check("bp valid_after_take", result_valid_out, 0);

    // Reset asserted while the first root is being computed
    send_ray(180, 200, 0, 0, 256, 1'b0);
    repeat (10) @(negedge clk_in);
    check("midrst busy", ray_ready_out, 0);
    #2 rst_in = 1'b1;
    #1;
    $display("[TB] midreset ready=%0d valid=%0d pix=(%0d,%0d)", ray_ready_out, result_valid_out, pix_x_out, pix_y_out);
    check("midrst ray_ready", ray_ready_out, 1);
    check("midrst result_valid", result_valid_out, 0);
    check("midrst outputs", {hit_out, steps_out, red_out, green_out, blue_out, pix_x_out, pix_y_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    run_ray("after_rst", 180, 200, 0, 0, 256, 0);

    // Back-to-back: second ray waits with valid high through the first DONE
    send_ray(100, 50, 0, 0, 256, 1'b1);
    pix_x_in = 11'd7;
    pix_y_in = 11'd9;
    dir_x_in = 64;
    dir_y_in = 0;
    dir_z_in = 240;
    wait_result(ok);
    check("b2b first done", ok, 1);
    check_result("b2b_first", 100, 50, 1, 1);
    result_ready_in = 1'b1;
    check("b2b not_ready_in_done", ray_ready_out, 0);
    @(negedge clk_in);
    result_ready_in = 1'b0;
    check("b2b ready_next_cycle", ray_ready_out, 1);
    @(negedge clk_in);
    check("b2b accepted", ray_ready_out, 0);
    ray_valid_in = 1'b0;
    model_march(64, 0, 240, 64, 4096, exp_hit, exp_steps);
    wait_result(ok);
    check("b2b second done", ok, 1);
    check_result("b2b_second", 7, 9, exp_hit, exp_steps);
    take_result();

    // Randomized rays against the model, with random result stalls
    for (int i = 0; i < 24; i++) begin
      int dx, dy, dz, x, y;
      x = int'($urandom_range(0, 2047));
      y = int'($urandom_range(0, 2047));
      if (i % 4 == 3) begin
        dx = int'($urandom_range(0, 512)) - 256;
        dy = int'($urandom_range(0, 512)) - 256;
        dz = int'($urandom_range(0, 512)) - 256;
      end else begin
        dx = int'($urandom_range(0, 192)) - 96;
        dy = int'($urandom_range(0, 192)) - 96;
        dz = int'($urandom_range(128, 256));
      end
      run_ray($sformatf("rand%0d", i), x, y, dx, dy, dz, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
